// File: rtl/atom_mem_arbiter.sv
// atom_mem_arbiter
//   2:1 arbiter that shares one memory port between the AtomRV instruction
//   fetch channel (IMEM) and the load/store channel (DMEM). Only one side is
//   granted at a time. The grant is held until the memory acks. Read data and
//   the ack go back to the granted side only. When both sides request in the
//   same idle cycle, the side that did not complete last wins (round-robin).
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a 16-bit timer aborts a grant after TIMEOUT cycles with no
//     ack. The abort returns ack with 32'hDEAD_BEEF and pulses err_o.
//     When undefined, the grant waits indefinitely and err_o is tied to 0.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-low reset
//   imem_addr_i/valid_i   fetch request (held until imem_ack_o)
//   imem_data_o/ack_o     fetch read data / 1-cycle completion pulse
//   dmem_addr/data/sel/we/valid_i  load/store request (held until dmem_ack_o)
//   dmem_data_o/ack_o     load data / 1-cycle completion pulse
//   mem_addr/data/sel/we/valid_o   shared memory port request
//   mem_data_i/ack_i      shared memory port response
//   err_o                 1-cycle pulse on timeout abort
module atom_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  input  logic                imem_valid_i,
  output logic [DATA_W-1:0]   imem_data_o,
  output logic                imem_ack_o,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_data_i,
  input  logic [DATA_W/8-1:0] dmem_sel_i,
  input  logic                dmem_we_i,
  input  logic                dmem_valid_i,
  output logic [DATA_W-1:0]   dmem_data_o,
  output logic                dmem_ack_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic                mem_we_o,
  output logic                mem_valid_o,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic                mem_ack_i,
  output logic                err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_GNT_I, ST_GNT_D} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  state_t state_q, state_d;
  side_t  last_q, last_d;

  logic gnt_i, gnt_d, granted;
  logic abort, ack_ok, done;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;

  // The abort cycle is the first granted cycle where the timer already equals
  // TIMEOUT. mem_valid_o is low in that cycle, so an ack that arrives then is
  // not counted. An ack in the last counted cycle completes normally.
  assign abort = granted && (timer_q == 16'(TIMEOUT));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign abort          = 1'b0;
`endif

  assign gnt_i   = (state_q == ST_GNT_I);
  assign gnt_d   = (state_q == ST_GNT_D);
  assign granted = gnt_i | gnt_d;
  assign ack_ok  = granted && !abort && mem_ack_i;
  assign done    = ack_ok | abort;

  // Datapath and response routing
  always_comb begin
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_sel_o   = '0;
    mem_we_o    = 1'b0;
    imem_ack_o  = 1'b0;
    imem_data_o = '0;
    dmem_ack_o  = 1'b0;
    dmem_data_o = '0;
    err_o       = abort;
    if (gnt_i) begin
      mem_valid_o = !abort;
      mem_addr_o  = imem_addr_i;
      mem_sel_o   = '1;
      imem_ack_o  = done;
      imem_data_o = abort ? ABORT_DATA : mem_data_i;
    end else if (gnt_d) begin
      mem_valid_o = !abort;
      mem_addr_o  = dmem_addr_i;
      mem_data_o  = dmem_data_i;
      mem_sel_o   = dmem_sel_i;
      mem_we_o    = dmem_we_i;
      dmem_ack_o  = done;
      dmem_data_o = abort ? ABORT_DATA : mem_data_i;
    end
  end

  // Next-state logic. On completion, the side that just finished is not
  // eligible, because its valid may still be high for one stale cycle. Only
  // the other side can be granted directly, and that grant has no bubble.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          state_d = (last_q == SIDE_I) ? ST_GNT_D : ST_GNT_I;
        end else if (imem_valid_i) begin
          state_d = ST_GNT_I;
        end else if (dmem_valid_i) begin
          state_d = ST_GNT_D;
        end
`ifdef ARB_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      ST_GNT_I: begin
        if (done) begin
          last_d  = SIDE_I;
          state_d = dmem_valid_i ? ST_GNT_D : ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        timer_d = done ? '0 : timer_q + 16'd1;
`endif
      end
      ST_GNT_D: begin
        if (done) begin
          last_d  = SIDE_D;
          state_d = imem_valid_i ? ST_GNT_I : ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        timer_d = done ? '0 : timer_q + 16'd1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= SIDE_I;
`ifdef ARB_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
module tb_atom_mem_arbiter;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_i;
  logic        imem_valid_i;
  logic [31:0] imem_data_o;
  logic        imem_ack_o;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_data_i;
  logic [3:0]  dmem_sel_i;
  logic        dmem_we_i;
  logic        dmem_valid_i;
  logic [31:0] dmem_data_o;
  logic        dmem_ack_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o;
  logic        mem_valid_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        err_o;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Memory responder settings: ack on the lat-th granted cycle (0 = never).
  int          lat = 1;
  logic        ack_force = 1'b0;
  logic [31:0] rd_value = 32'h0;

  atom_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_addr_i(imem_addr_i), .imem_valid_i(imem_valid_i),
    .imem_data_o(imem_data_o), .imem_ack_o(imem_ack_o),
    .dmem_addr_i(dmem_addr_i), .dmem_data_i(dmem_data_i),
    .dmem_sel_i(dmem_sel_i), .dmem_we_i(dmem_we_i), .dmem_valid_i(dmem_valid_i),
    .dmem_data_o(dmem_data_o), .dmem_ack_o(dmem_ack_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o),
    .mem_we_o(mem_we_o), .mem_valid_o(mem_valid_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // owner: 0 = nobody, 1 = IMEM, 2 = DMEM. waited counts granted cycles with no ack.
  int  m_owner = 0;
  int  m_last  = 1;
  int  m_wait  = 0;
  bit  m_on    = 1'b0;

  function automatic bit m_timed_out();
`ifdef ARB_TIMEOUT_EN
    return (m_owner != 0) && (m_wait == TO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk_i) begin
    bit fin;
    if (!rst_i) begin
      m_owner = 0; m_last = 1; m_wait = 0; m_on = 1'b1;
    end else if (m_owner == 0) begin
      if (imem_valid_i && dmem_valid_i) m_owner = 3 - m_last;
      else if (imem_valid_i)            m_owner = 1;
      else if (dmem_valid_i)            m_owner = 2;
      m_wait = 0;
    end else begin
      fin = m_timed_out() || (mem_ack_i === 1'b1);
      if (fin) begin
        m_last  = m_owner;
        m_owner = (m_owner == 1) ? (dmem_valid_i ? 2 : 0) : (imem_valid_i ? 1 : 0);
        m_wait  = 0;
      end else begin
        m_wait++;
      end
    end
  end

  // One compare process checks every output against the model on every cycle.
  always @(negedge clk_i) begin
    logic        e_valid, e_we, e_iack, e_dack, e_err, ab;
    logic [31:0] e_addr, e_wdata, e_idata, e_ddata, rsp;
    logic [3:0]  e_sel;
    if (m_on) begin
      ab = m_timed_out();
      e_valid = 0; e_we = 0; e_iack = 0; e_dack = 0; e_err = ab;
      e_addr = 0; e_wdata = 0; e_idata = 0; e_ddata = 0; e_sel = 0;
      rsp = ab ? 32'hDEAD_BEEF : mem_data_i;
      if (m_owner == 1) begin
        e_valid = !ab; e_addr = imem_addr_i; e_sel = 4'hF;
        e_iack = ab || mem_ack_i; e_idata = rsp;
      end else if (m_owner == 2) begin
        e_valid = !ab; e_addr = dmem_addr_i; e_wdata = dmem_data_i;
        e_sel = dmem_sel_i; e_we = dmem_we_i;
        e_dack = ab || mem_ack_i; e_ddata = rsp;
      end
      chk("mem_valid_o", 64'(mem_valid_o), 64'(e_valid));
      chk("mem_addr_o",  64'(mem_addr_o),  64'(e_addr));
      chk("mem_data_o",  64'(mem_data_o),  64'(e_wdata));
      chk("mem_sel_o",   64'(mem_sel_o),   64'(e_sel));
      chk("mem_we_o",    64'(mem_we_o),    64'(e_we));
      chk("imem_ack_o",  64'(imem_ack_o),  64'(e_iack));
      chk("imem_data_o", 64'(imem_data_o), 64'(e_idata));
      chk("dmem_ack_o",  64'(dmem_ack_o),  64'(e_dack));
      chk("dmem_data_o", 64'(dmem_data_o), 64'(e_ddata));
      chk("err_o",       64'(err_o),       64'(e_err));
    end
  end

  // ---------------- Memory responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_valid_o === 1'b1) begin
        cnt++;
        mem_ack_i = (lat != 0) && (cnt >= lat);
        if (mem_ack_i) cnt = 0;
      end else begin
        cnt = 0;
        mem_ack_i = ack_force;
      end
      mem_data_i = rd_value;
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic wait_ack(input bit dside, input int maxc, input string nm, output int steps);
    steps = 0;
    while (steps < maxc && ((dside ? dmem_ack_o : imem_ack_o) !== 1'b1)) begin
      step();
      steps++;
    end
    chk(nm, 64'(dside ? dmem_ack_o : imem_ack_o), 64'd1);
  endtask

  initial begin
    int s;
    rst_i = 1'b0;
    imem_addr_i = 32'h0000_0000; imem_valid_i = 1'b1;
    dmem_addr_i = 32'h0000_1000; dmem_data_i = '0; dmem_sel_i = 4'hF;
    dmem_we_i = 1'b0; dmem_valid_i = 1'b1;

    // T1: reset with both valids high, then DMEM wins first contention
    step(); step();
    chk("t1_rst_valid", 64'(mem_valid_o), 64'd0);
    chk("t1_rst_acks", 64'({imem_ack_o, dmem_ack_o}), 64'd0);
    rst_i = 1'b1;
    step();
    chk("t1_first_dack", 64'(dmem_ack_o), 64'd1);
    chk("t1_first_addr", 64'(mem_addr_o), 64'h1000);
    dmem_valid_i = 1'b0;
    step();
    chk("t1_then_iack", 64'(imem_ack_o), 64'd1);
    imem_valid_i = 1'b0;
    step();

    // T2: IMEM only, ack on third granted cycle
    rd_value = 32'h0000_0013; lat = 3;
    imem_addr_i = 32'h100; imem_valid_i = 1'b1;
    wait_ack(1'b0, 20, "t2_ack", s);
    chk("t2_latency", 64'(s), 64'd3);
    chk("t2_data", 64'(imem_data_o), 64'h13);
    chk("t2_sel", 64'(mem_sel_o), 64'hF);
    chk("t2_we", 64'(mem_we_o), 64'd0);
    imem_valid_i = 1'b0;
    step();
    chk("t2_idle", 64'(mem_valid_o), 64'd0);

    // T3: contention, single-cycle acks -> D,I,D,I with no gap
    lat = 1;
    imem_addr_i = 32'h200; dmem_addr_i = 32'h3000; dmem_we_i = 1'b0;
    imem_valid_i = 1'b1; dmem_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_dack", 64'(dmem_ack_o), 64'((k % 2) == 0));
      chk("t3_iack", 64'(imem_ack_o), 64'((k % 2) == 1));
      chk("t3_busy", 64'(mem_valid_o), 64'd1);
    end
    imem_valid_i = 1'b0; dmem_valid_i = 1'b0;
    step();
    chk("t3_idle", 64'(mem_valid_o), 64'd0);

    // T4: store fields pass through unchanged
    lat = 2;
    dmem_addr_i = 32'h2000; dmem_data_i = 32'hA5A5_5A5A; dmem_sel_i = 4'b0011;
    dmem_we_i = 1'b1; dmem_valid_i = 1'b1;
    step();
    chk("t4_addr", 64'(mem_addr_o), 64'h2000);
    chk("t4_data", 64'(mem_data_o), 64'hA5A5_5A5A);
    chk("t4_sel", 64'(mem_sel_o), 64'h3);
    chk("t4_we", 64'(mem_we_o), 64'd1);
    chk("t4_iack", 64'(imem_ack_o), 64'd0);
    wait_ack(1'b1, 10, "t4_ack", s);
    chk("t4_latency", 64'(s), 64'd1);
    dmem_valid_i = 1'b0; dmem_we_i = 1'b0; dmem_sel_i = 4'hF; dmem_data_i = '0;
    step();

    // T5: stale valid after ack is not regranted; ack while idle is ignored
    lat = 1;
    dmem_addr_i = 32'h2004; dmem_valid_i = 1'b1;
    step();
    chk("t5_ack", 64'(dmem_ack_o), 64'd1);
    step();
    chk("t5_no_regrant", 64'(mem_valid_o), 64'd0);
    chk("t5_no_ack", 64'(dmem_ack_o), 64'd0);
    dmem_valid_i = 1'b0; ack_force = 1'b1;
    step();
    chk("t5_idle_ack_ignored", 64'({imem_ack_o, dmem_ack_o}), 64'd0);
    ack_force = 1'b0;
    step();

    // T6: memory never acks
    lat = 0;
    imem_addr_i = 32'h400; imem_valid_i = 1'b1;
`ifdef ARB_TIMEOUT_EN
    wait_ack(1'b0, 30, "t6_abort_ack", s);
    chk("t6_abort_cycle", 64'(s), 64'd9);
    chk("t6_err", 64'(err_o), 64'd1);
    chk("t6_data", 64'(imem_data_o), 64'hDEAD_BEEF);
    chk("t6_valid_low", 64'(mem_valid_o), 64'd0);
    imem_valid_i = 1'b0;
    step();
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t6_held", 64'(mem_valid_o), 64'd1);
      chk("t6_no_ack", 64'(imem_ack_o), 64'd0);
    end
    lat = 1;
    wait_ack(1'b0, 5, "t6_late_ack", s);
    chk("t6_late_latency", 64'(s), 64'd1);
    imem_valid_i = 1'b0;
    step();
`endif

    // T7: reset in the middle of a grant drops it
    lat = 0;
    dmem_addr_i = 32'h2008; dmem_valid_i = 1'b1;
    step();
    chk("t7_granted", 64'(mem_valid_o), 64'd1);
    rst_i = 1'b0; dmem_valid_i = 1'b0;
    step();
    chk("t7_dropped", 64'(mem_valid_o), 64'd0);
    rst_i = 1'b1;
    step();
    chk("t7_idle", 64'(mem_valid_o), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
